// File: rtl/mseq_modem.sv
// Spread-spectrum modem: m-sequence chip transmitter and correlating receiver.
// Each data bit is one full m-sequence period, sent true for 1, inverted for 0.
module mseq_modem #(
  parameter int          N      = 5,
  parameter logic [N-1:0] TAPS  = 5'b10100,
  parameter int          DATA_W = 8,
  parameter int          THRESH = 28
) (
  input  logic                CLK_50MHZ,
  input  logic                RST,
  input  logic [DATA_W-1:0]   tx_data,
  input  logic                tx_start,
  output logic                tx_busy,
  output logic                out_fun,
  input  logic                rx_in,
  output logic [DATA_W-1:0]   data,
  output logic                data_valid,
  output logic                rx_err,
  output logic [N-1:0]        corr,
  output logic [2**N-2:0]     buff_wr
);

  localparam int L  = 2**N - 1;
  localparam int SW = $clog2(DATA_W + 1);

  localparam logic [N-1:0]  LC       = N'(L);
  localparam logic [N-1:0]  TH_HI    = N'(THRESH);
  localparam logic [N-1:0]  TH_LO    = N'(L - THRESH);
  localparam logic [SW-1:0] SYM_LAST = SW'(DATA_W);
  localparam logic [SW-1:0] BIT_LAST = SW'(DATA_W - 1);
  localparam logic [N-1:0]  SEED     = '1;
  localparam logic [N-1:0]  SEED_NXT = {SEED[N-2:0], ^(SEED & TAPS)};

  function automatic logic [L-1:0] gen_ref();
    logic [L-1:0] r;
    logic [N-1:0] s;
    r = '0;
    s = '1;
    for (int k = 0; k < L; k++) begin
      r[L-1-k] = s[N-1];
      s = {s[N-2:0], ^(s & TAPS)};
    end
    return r;
  endfunction

  localparam logic [L-1:0] REF = gen_ref();

  typedef enum logic {TX_IDLE, TX_SEND} tx_st_e;
  typedef enum logic {RX_SEARCH, RX_RECV} rx_st_e;

  tx_st_e            tx_st_q, tx_st_d;
  logic [N-1:0]      lfsr_q, lfsr_d;
  logic [N-1:0]      chip_q, chip_d;
  logic [SW-1:0]     sym_q, sym_d;
  logic [DATA_W:0]   frm_q, frm_d;
  logic              out_q, out_d;

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      tx_st_q <= TX_IDLE;
      lfsr_q  <= '1;
      chip_q  <= '0;
      sym_q   <= '0;
      frm_q   <= '0;
      out_q   <= 1'b0;
    end else begin
      tx_st_q <= tx_st_d;
      lfsr_q  <= lfsr_d;
      chip_q  <= chip_d;
      sym_q   <= sym_d;
      frm_q   <= frm_d;
      out_q   <= out_d;
    end
  end

  // chip_q counts chips already emitted in the current symbol
  always_comb begin
    logic load;
    tx_st_d = tx_st_q;
    lfsr_d  = lfsr_q;
    chip_d  = chip_q;
    sym_d   = sym_q;
    frm_d   = frm_q;
    out_d   = 1'b0;
    load    = 1'b0;
    unique case (tx_st_q)
      TX_IDLE: load = tx_start;
      TX_SEND: begin
        if (chip_q == LC) begin
          if (sym_q == SYM_LAST) begin
            tx_st_d = TX_IDLE;
            load    = tx_start;
          end else begin
            sym_d  = sym_q + 1'b1;
            frm_d  = {frm_q[DATA_W-1:0], 1'b0};
            lfsr_d = SEED_NXT;
            chip_d = {{(N-1){1'b0}}, 1'b1};
            out_d  = ~(SEED[N-1] ^ frm_q[DATA_W-1]);
          end
        end else begin
          lfsr_d = {lfsr_q[N-2:0], ^(lfsr_q & TAPS)};
          chip_d = chip_q + 1'b1;
          out_d  = ~(lfsr_q[N-1] ^ frm_q[DATA_W]);
        end
      end
    endcase
    if (load) begin
      tx_st_d = TX_SEND;
      frm_d   = {1'b1, tx_data};
      sym_d   = '0;
      chip_d  = {{(N-1){1'b0}}, 1'b1};
      lfsr_d  = SEED_NXT;
      out_d   = SEED[N-1];
    end
  end

  assign tx_busy = (tx_st_q == TX_SEND);
  assign out_fun = out_q;

  rx_st_e            rx_st_q, rx_st_d;
  logic [L-1:0]      buff_q;
  logic [N-1:0]      wait_q, wait_d;
  logic [SW-1:0]     bits_q, bits_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              dv_q, dv_d;
  logic              err_q, err_d;
  logic [N-1:0]      corr_w;
  logic              hi, lo;

  assign corr_w = N'($countones(~(buff_q ^ REF)));
  assign hi     = (corr_w >= TH_HI);
  assign lo     = (corr_w <= TH_LO);

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      rx_st_q <= RX_SEARCH;
      buff_q  <= '0;
      wait_q  <= '0;
      bits_q  <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      rx_st_q <= rx_st_d;
      buff_q  <= {buff_q[L-2:0], rx_in};
      wait_q  <= wait_d;
      bits_q  <= bits_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
    end
  end

  // wait_q reaches L exactly one symbol after the last accepted window
  always_comb begin
    rx_st_d = rx_st_q;
    wait_d  = wait_q;
    bits_d  = bits_q;
    sh_d    = sh_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    err_d   = 1'b0;
    unique case (rx_st_q)
      RX_SEARCH: begin
        if (hi) begin
          rx_st_d = RX_RECV;
          wait_d  = {{(N-1){1'b0}}, 1'b1};
          bits_d  = '0;
        end
      end
      RX_RECV: begin
        if (wait_q == LC) begin
          wait_d = {{(N-1){1'b0}}, 1'b1};
          if (hi || lo) begin
            sh_d   = {sh_q[DATA_W-2:0], hi};
            bits_d = bits_q + 1'b1;
            if (bits_q == BIT_LAST) begin
              data_d  = {sh_q[DATA_W-2:0], hi};
              dv_d    = 1'b1;
              rx_st_d = RX_SEARCH;
            end
          end else begin
            err_d   = 1'b1;
            rx_st_d = RX_SEARCH;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
    endcase
  end

  assign data       = data_q;
  assign data_valid = dv_q;
  assign rx_err     = err_q;
  assign corr       = corr_w;
  assign buff_wr    = buff_q;

endmodule
